// File: rtl/scmp_pkg.sv
// Shared types and result logic for the sequential magnitude comparator.
// Optional min/max outputs in the top level are enabled by SCMP_MINMAX_EN.
package scmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic lt;
    logic eq;
  } result_t;

  // Signed less-than is N xor V; unsigned less-than is a borrow (no carry out).
  function automatic result_t calc_result(
    input logic c_out,
    input logic c_msb,
    input logic s_msb,
    input logic zero,
    input logic is_signed
  );
    result_t r;
    logic    lt;
    if (is_signed) begin
      lt = s_msb ^ (c_out ^ c_msb);
    end else begin
      lt = ~c_out;
    end
    r.lt = lt;
    r.eq = zero & ~lt;
    r.gt = ~lt & ~r.eq;
    return r;
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/scmp_digit_slice.sv
// DIGIT-bit ripple subtractor slice: computes a + ~b + cin.
module scmp_digit_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
      fulladder u_fa (
        .i_a    (i_a[gi]),
        .i_b    (~i_b[gi]),
        .i_cin  (w_c[gi]),
        .o_sum  (o_sum[gi]),
        .o_cout (w_c[gi+1])
      );
    end
  endgenerate

  assign o_cout = w_c[DIGIT];
  assign o_cmsb = w_c[DIGIT-1];

endmodule

// File: rtl/seq_signed_comparator.sv
// Digit-serial signed/unsigned magnitude comparator with start/done handshake.
// Define SCMP_MINMAX_EN to add registered max_out/min_out outputs.
module seq_signed_comparator
  import scmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic             x_gt_y,
  output logic             x_lt_y,
  output logic             x_eq_y
`ifdef SCMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("seq_signed_comparator: WIDTH must be >= 2");
    end
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("seq_signed_comparator: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic             r_carry;
  logic             r_zero;
  logic [CNT_W-1:0] r_cnt;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq;

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_zero_next;
  logic             w_last;
  logic             w_accept;
  result_t          w_res;

  assign w_a_dig     = r_a[int'(r_cnt) * DIGIT +: DIGIT];
  assign w_b_dig     = r_b[int'(r_cnt) * DIGIT +: DIGIT];
  assign w_last      = (r_cnt == LAST);
  assign w_accept    = start && (r_state != RUN);
  assign w_zero_next = r_zero & ~(|w_sum);
  // Only meaningful on the last digit, where slice top-bit carry is c_msb.
  assign w_res       = calc_result(w_cout, w_cmsb, w_sum[DIGIT-1], w_zero_next, r_signed);

  scmp_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .i_a    (w_a_dig),
    .i_b    (w_b_dig),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_carry  <= 1'b1;
      r_zero   <= 1'b1;
      r_cnt    <= '0;
      r_gt     <= 1'b0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_signed <= is_signed;
      r_carry  <= 1'b1;
      r_zero   <= 1'b1;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_carry <= w_cout;
      r_zero  <= w_zero_next;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_gt <= w_res.gt;
        r_lt <= w_res.lt;
        r_eq <= w_res.eq;
      end
    end
  end

`ifdef SCMP_MINMAX_EN
  logic [WIDTH-1:0] r_max;
  logic [WIDTH-1:0] r_min;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max <= '0;
      r_min <= '0;
    end else if (r_state == RUN && w_last && !w_accept) begin
      r_max <= (w_res.gt | w_res.eq) ? r_a : r_b;
      r_min <= (w_res.gt | w_res.eq) ? r_b : r_a;
    end
  end

  assign max_out = r_max;
  assign min_out = r_min;
`endif

  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);
  assign x_gt_y = r_gt;
  assign x_lt_y = r_lt;
  assign x_eq_y = r_eq;

endmodule

// File: tb/tb_seq_signed_comparator.sv
// Scoreboard bench for seq_signed_comparator: DIGIT=1 and DIGIT=4 instances.
// Min/max outputs are checked only when SCMP_MINMAX_EN is defined.
module tb_seq_signed_comparator;

  typedef struct {
    logic       gt;
    logic       lt;
    logic       eq;
    logic [7:0] mx;
    logic [7:0] mn;
    int         done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic       start1 = 1'b0, s1 = 1'b0;
  logic [7:0] a1 = '0, b1 = '0;
  logic       busy1, done1, gt1, lt1, eq1;
  logic       start4 = 1'b0, s4 = 1'b0;
  logic [7:0] a4 = '0, b4 = '0;
  logic       busy4, done4, gt4, lt4, eq4;
`ifdef SCMP_MINMAX_EN
  logic [7:0] mx1, mn1, mx4, mn4;
`endif

  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_signed_comparator #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .is_signed(s1),
    .busy(busy1), .done(done1), .x_gt_y(gt1), .x_lt_y(lt1), .x_eq_y(eq1)
`ifdef SCMP_MINMAX_EN
    , .max_out(mx1), .min_out(mn1)
`endif
  );

  seq_signed_comparator #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .is_signed(s4),
    .busy(busy4), .done(done4), .x_gt_y(gt4), .x_lt_y(lt4), .x_eq_y(eq4)
`ifdef SCMP_MINMAX_EN
    , .max_out(mx4), .min_out(mn4)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (q1.size() == 0) begin
        check("d1_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("d1_done_cycle", cyc, e.done_cyc);
        check("d1_flags", {gt1, lt1, eq1}, {e.gt, e.lt, e.eq});
`ifdef SCMP_MINMAX_EN
        check("d1_max", mx1, e.mx);
        check("d1_min", mn1, e.mn);
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done4) begin
      if (q4.size() == 0) begin
        check("d4_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("d4_done_cycle", cyc, e.done_cyc);
        check("d4_flags", {gt4, lt4, eq4}, {e.gt, e.lt, e.eq});
`ifdef SCMP_MINMAX_EN
        check("d4_max", mx4, e.mx);
        check("d4_min", mn4, e.mn);
`endif
      end
    end
  end

  function automatic exp_t mk(input logic [2:0] f, input logic [7:0] mx, input logic [7:0] mn,
                              input int dc);
    exp_t e;
    e.gt = f[2]; e.lt = f[1]; e.eq = f[0];
    e.mx = mx; e.mn = mn; e.done_cyc = dc;
    return e;
  endfunction

  task automatic drain(input int which);
    int k = 0;
    while (((which == 1) ? q1.size() : q4.size()) != 0 && k < 40) begin
      @(posedge clk);
      k++;
    end
    if (((which == 1) ? q1.size() : q4.size()) != 0) begin
      check("timeout_waiting_done", 0, 1);
      if (which == 1) q1.delete(); else q4.delete();
    end
    #1;
  endtask

  // Called just after a posedge with the DUT idle. f = {gt,lt,eq}.
  task automatic op(input int which, input logic [7:0] a, input logic [7:0] b, input logic s,
                    input logic [2:0] f, input logic [7:0] mx, input logic [7:0] mn);
    if (which == 1) begin
      q1.push_back(mk(f, mx, mn, cyc + 1 + 8));
      a1 = a; b1 = b; s1 = s; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~a; b1 = ~b; s1 = ~s;
    end else begin
      q4.push_back(mk(f, mx, mn, cyc + 1 + 2));
      a4 = a; b4 = b; s4 = s; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0; a4 = ~a; b4 = ~b; s4 = ~s;
    end
    drain(which);
    repeat (2) @(posedge clk);
    #1;
    if (which == 1) check("d1_flags_held", {gt1, lt1, eq1}, f);
    else            check("d4_flags_held", {gt4, lt4, eq4}, f);
  endtask

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    check("rst_d1_state", {busy1, done1, gt1, lt1, eq1}, 0);
    check("rst_d4_state", {busy4, done4, gt4, lt4, eq4}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(1, 8'h80, 8'h7F, 1'b1, 3'b010, 8'h7F, 8'h80);
    op(1, 8'h80, 8'h7F, 1'b0, 3'b100, 8'h80, 8'h7F);
    op(1, 8'h7F, 8'h80, 1'b1, 3'b100, 8'h7F, 8'h80);
    op(1, 8'hFF, 8'hFF, 1'b1, 3'b001, 8'hFF, 8'hFF);
    op(4, 8'h05, 8'hFB, 1'b1, 3'b100, 8'h05, 8'hFB);
    op(4, 8'h05, 8'hFB, 1'b0, 3'b010, 8'hFB, 8'h05);
    op(1, 8'hF0, 8'h10, 1'b1, 3'b010, 8'h10, 8'hF0);
    op(1, 8'hF0, 8'h10, 1'b0, 3'b100, 8'hF0, 8'h10);

    // Starts while busy are ignored; a start in DONE runs back-to-back.
    q1.push_back(mk(3'b010, 8'h7F, 8'h80, cyc + 1 + 8));
    a1 = 8'h80; b1 = 8'h7F; s1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    a1 = 8'h7F; b1 = 8'h80; s1 = 1'b0; start1 = 1'b0;
    check("d1_busy_in_run", busy1, 1);
    @(posedge clk); #1;
    start1 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    start1 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done1 && k < 20);
    if (!done1) check("d1_first_done_timeout", 0, 1);
    q1.push_back(mk(3'b010, 8'h20, 8'h10, cyc + 9));
    a1 = 8'h10; b1 = 8'h20; s1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("d1_busy_back_to_back", busy1, 1);
    drain(1);

    // Reset in the middle of a run aborts immediately.
    a1 = 8'h7F; b1 = 8'h80; s1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_d1_state", {busy1, done1, gt1, lt1, eq1}, 0);
    check("midrst_d4_state", {busy4, done4, gt4, lt4, eq4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    op(1, 8'h10, 8'h10, 1'b1, 3'b001, 8'h10, 8'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
